pb_program_loader: RTL and testbench
====================================

# pb_program_loader

Sequencer for the PicoBlaze program ROM's load port. It receives a framed program image as a byte stream over a valid/ready handshake and assembles 18-bit instructions. It writes them into the ROM through LOAD_ADDRESS/LOAD_INSTRUCTION/LOAD_WE and holds the KCPSM3 in reset while the image is rewritten. It sits between a host byte source (UART or debug bridge) and the config ROM/PicoBlaze pair, with the ROM load clock tied to CLK.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes inside a frame.
- RELEASE_CYCLES, 16, cycles CPU_RESET stays high after a successful load or after reset.
- CLK  in  1  single clock; also drives the ROM load port.
- RESET  in  1  asynchronous, active-high.
- RX_DATA  in  8  incoming byte.
- RX_VALID  in  1  RX_DATA valid.
- RX_READY  out  1  loader accepts the byte this cycle.
- LOAD_ADDRESS  out  10  ROM write address.
- LOAD_INSTRUCTION  out  18  ROM write data.
- LOAD_WE  out  1  ROM write strobe, one cycle per instruction.
- CPU_RESET  out  1  PicoBlaze reset, active-high.
- BUSY  out  1  frame in progress (any state except IDLE).
- DONE  out  1  last frame loaded and verified; sticky.
- ERROR  out  1  last frame failed; sticky.
- ERR_CODE  out  2  00 none, 01 checksum, 10 timeout.

## Operation
- Byte accepted when RX_VALID && RX_READY. RX_READY = 1 in IDLE, CNT_HI, CNT_LO, B0, B1, B2, CSUM; 0 in WRITE, RELEASE.
- Frame: SYNC, CNT_HI, CNT_LO, then N×(B0,B1,B2), then CSUM.
  - N−1 = {CNT_HI[1:0], CNT_LO}; N ranges 1..1024. CNT_HI[7:2] is ignored.
  - Instruction = {B0[1:0], B1, B2}; B0[7:2] is ignored.
- States:
  - IDLE: non-sync bytes are discarded. On the sync byte: CPU_RESET←1, DONE←0, ERROR←0, ERR_CODE←00, checksum←0, index←0, go to CNT_HI.
  - CNT_HI → CNT_LO → B0 → B1 → B2 → WRITE.
  - WRITE: LOAD_WE=1 with LOAD_ADDRESS=index. If index == N−1, go to CSUM; else index+1 and go to B0.
  - CSUM: accept the byte. If the 8-bit sum of every byte after SYNC (including CSUM) is 0x00, go to RELEASE. Otherwise ERROR←1, ERR_CODE←01, go to IDLE with CPU_RESET held at 1.
  - RELEASE: count RELEASE_CYCLES with CPU_RESET=1, then CPU_RESET←0 and go to IDLE. DONE←1 only when RELEASE was entered from CSUM.
- Timeout: the counter clears on every accepted byte and runs in CNT_HI..CSUM. When it reaches TIMEOUT_CYCLES−1: ERROR←1, ERR_CODE←10, go to IDLE, CPU_RESET stays 1. Partially written ROM contents are left in place.
- The checksum is a mod-256 accumulation. The address never wraps because index stops at N−1 ≤ 1023.
- After ERROR the CPU stays in reset until a good frame completes. Only a new sync byte clears the ERROR/DONE flags.

## Timing
- Reset values:
  - state=RELEASE with counter 0, so CPU_RESET=1 and BUSY=1.
  - RX_READY=0, LOAD_WE=0, LOAD_ADDRESS=0, LOAD_INSTRUCTION=0, DONE=0, ERROR=0, ERR_CODE=00.
  - After RESET falls, CPU_RESET deasserts after RELEASE_CYCLES cycles; the existing ROM image runs.
- Async reset mid-frame forces these values immediately. The partial image then runs after release, so the host must reload.
- All outputs are registered.
- CPU_RESET rises the cycle after the sync byte handshake.
- LOAD_WE is high exactly in the cycle after the B2 handshake. LOAD_ADDRESS and LOAD_INSTRUCTION are valid that cycle and hold until the next write.
- Throughput is 3 bytes per 4 cycles within the instruction body; other bytes are accepted 1 per cycle.
- CPU_RESET falls RELEASE_CYCLES+1 cycles after the CSUM handshake; DONE rises in the same cycle.
- RX_VALID deasserted between bytes is legal, subject to the timeout.

## Test plan
- Reset release → CPU_RESET=1 for 16 cycles after RESET falls, then 0. LOAD_WE never pulses. DONE=ERROR=0.
- Good frame A5,00,01,00,12,34,03,AB,CD,3E:
  - Writes addr 0=18'h01234 and addr 1=18'h3ABCD, one LOAD_WE pulse each.
  - CPU_RESET falls 17 cycles after the CSUM handshake. DONE=1, ERR_CODE=00.
- Same frame with CSUM=3F → both writes occur. Then ERROR=1, ERR_CODE=01, DONE=0, CPU_RESET stays 1. A following good frame clears ERROR and releases the CPU.
- Bytes 00,FF before A5 are discarded (RX_READY high, no state change). A 1024-instruction frame (CNT 03,FF) produces 1024 LOAD_WE pulses, addresses 0..1023 in order, with no wrap.
- TIMEOUT_CYCLES=100: frame stops after CNT_LO → at cycle 100 after the last handshake ERROR=1, ERR_CODE=10, BUSY=0, CPU_RESET=1.
- RESET pulse during B1 of instruction 5 → outputs take reset values asynchronously, no further LOAD_WE, and the RELEASE sequence repeats.

Source files
------------

// File: rtl/pb_program_loader.sv
// PicoBlaze program ROM loader: receives a framed byte stream, writes 18-bit
// instructions through the ROM load port and holds the CPU in reset meanwhile.
module pb_program_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         RELEASE_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic [9:0]  LOAD_ADDRESS,
  output logic [17:0] LOAD_INSTRUCTION,
  output logic        LOAD_WE,
  output logic        CPU_RESET,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [1:0]  ERR_CODE
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_B0, S_B1, S_B2, S_WRITE, S_CSUM, S_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic          rx_ready_q, rx_ready_d;
  logic [9:0]    load_addr_q, load_addr_d;
  logic [17:0]   load_instr_q, load_instr_d;
  logic          load_we_q, load_we_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [7:0]    csum_q, csum_d;
  logic [9:0]    index_q, index_d;
  logic [9:0]    last_q, last_d;
  logic [1:0]    b0_q, b0_d;
  logic [7:0]    b1_q, b1_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] rel_q, rel_d;
  logic          from_csum_q, from_csum_d;
  logic          accept;
  logic          in_frame;
  logic [7:0]    sum_next;

  always_comb begin
    state_d      = state_q;
    load_addr_d  = load_addr_q;
    load_instr_d = load_instr_q;
    load_we_d    = 1'b0;
    cpu_reset_d  = cpu_reset_q;
    done_d       = done_q;
    error_d      = error_q;
    err_code_d   = err_code_q;
    csum_d       = csum_q;
    index_d      = index_q;
    last_d       = last_q;
    b0_d         = b0_q;
    b1_d         = b1_q;
    rel_d        = rel_q;
    from_csum_d  = from_csum_q;
    accept       = RX_VALID && rx_ready_q;
    sum_next     = csum_q + RX_DATA;
    in_frame     = state_q inside {S_CNT_HI, S_CNT_LO, S_B0, S_B1, S_B2, S_WRITE, S_CSUM};

    // Idle-gap counter: cleared by every accepted byte, only runs inside a frame
    tmo_d = '0;
    if (in_frame && !accept) tmo_d = tmo_q + TW'(1);
    if (accept && state_q != S_IDLE) csum_d = sum_next;

    case (state_q)
      S_IDLE: begin
        if (accept && RX_DATA == SYNC_BYTE) begin
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          err_code_d  = 2'b00;
          csum_d      = 8'h00;
          index_d     = 10'd0;
          state_d     = S_CNT_HI;
        end
      end
      S_CNT_HI: if (accept) begin
        last_d[9:8] = RX_DATA[1:0];
        state_d     = S_CNT_LO;
      end
      S_CNT_LO: if (accept) begin
        last_d[7:0] = RX_DATA;
        state_d     = S_B0;
      end
      S_B0: if (accept) begin
        b0_d    = RX_DATA[1:0];
        state_d = S_B1;
      end
      S_B1: if (accept) begin
        b1_d    = RX_DATA;
        state_d = S_B2;
      end
      S_B2: if (accept) begin
        load_instr_d = {b0_q, b1_q, RX_DATA};
        load_addr_d  = index_q;
        load_we_d    = 1'b1;
        state_d      = S_WRITE;
      end
      S_WRITE: begin
        if (index_q == last_q) begin
          state_d = S_CSUM;
        end else begin
          index_d = index_q + 10'd1;
          state_d = S_B0;
        end
      end
      S_CSUM: if (accept) begin
        if (sum_next == 8'h00) begin
          rel_d       = '0;
          from_csum_d = 1'b1;
          state_d     = S_RELEASE;
        end else begin
          error_d    = 1'b1;
          err_code_d = 2'b01;
          state_d    = S_IDLE;
        end
      end
      S_RELEASE: begin
        if (rel_q == RW'(RELEASE_CYCLES)) begin
          cpu_reset_d = 1'b0;
          done_d      = from_csum_q;
          from_csum_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          rel_d = rel_q + RW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (in_frame && !accept && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      error_d    = 1'b1;
      err_code_d = 2'b10;
      state_d    = S_IDLE;
    end

    rx_ready_d = state_d inside {S_IDLE, S_CNT_HI, S_CNT_LO, S_B0, S_B1, S_B2, S_CSUM};
    busy_d     = (state_d != S_IDLE);
  end

  // Reset parks the loader in RELEASE so the existing ROM image starts after the count
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_RELEASE;
      rx_ready_q   <= 1'b0;
      load_addr_q  <= '0;
      load_instr_q <= '0;
      load_we_q    <= 1'b0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= 2'b00;
      csum_q       <= '0;
      index_q      <= '0;
      last_q       <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      tmo_q        <= '0;
      rel_q        <= '0;
      from_csum_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= rx_ready_d;
      load_addr_q  <= load_addr_d;
      load_instr_q <= load_instr_d;
      load_we_q    <= load_we_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      csum_q       <= csum_d;
      index_q      <= index_d;
      last_q       <= last_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      tmo_q        <= tmo_d;
      rel_q        <= rel_d;
      from_csum_q  <= from_csum_d;
    end
  end

  assign RX_READY         = rx_ready_q;
  assign LOAD_ADDRESS     = load_addr_q;
  assign LOAD_INSTRUCTION = load_instr_q;
  assign LOAD_WE          = load_we_q;
  assign CPU_RESET        = cpu_reset_q;
  assign BUSY             = busy_q;
  assign DONE             = done_q;
  assign ERROR            = error_q;
  assign ERR_CODE         = err_code_q;

endmodule

// File: tb/tb_pb_program_loader.sv
// Testbench for pb_program_loader: directed frames with a write scoreboard
// checked by an independent LOAD_WE monitor.
module tb_pb_program_loader;

  localparam int TIMEOUT = 100;
  localparam int RELEASE = 16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic        RX_READY;
  logic [9:0]  LOAD_ADDRESS;
  logic [17:0] LOAD_INSTRUCTION;
  logic        LOAD_WE;
  logic        CPU_RESET;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic [1:0]  ERR_CODE;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [27:0] expQ[$];
  logic [7:0]  txQ[$];

  pb_program_loader #(
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TIMEOUT), .RELEASE_CYCLES(RELEASE)
  ) dut (
    .CLK(CLK), .RESET(RESET), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_READY(RX_READY), .LOAD_ADDRESS(LOAD_ADDRESS),
    .LOAD_INSTRUCTION(LOAD_INSTRUCTION), .LOAD_WE(LOAD_WE),
    .CPU_RESET(CPU_RESET), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
    .ERR_CODE(ERR_CODE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle <= cycle + 1;

  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endfunction

  // Monitor: every ROM write must match the oldest expected write
  always @(negedge CLK) begin
    if (LOAD_WE === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: actual addr=%0h instr=%0h required=no write",
                 LOAD_ADDRESS, LOAD_INSTRUCTION);
      end else begin
        logic [27:0] e;
        e = expQ.pop_front();
        checkOutput("write_addr", 32'(LOAD_ADDRESS), 32'(e[27:18]));
        checkOutput("write_instr", 32'(LOAD_INSTRUCTION), 32'(e[17:0]));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one byte from a negedge and return at the negedge after its handshake
  task automatic applyStimulus(input logic [7:0] b);
    int w;
    w = 0;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    while (RX_READY !== 1'b1 && w < 64) begin
      @(negedge CLK);
      w++;
    end
    if (RX_READY !== 1'b1) checkOutput("rx_ready_wait", 32'(RX_READY), 32'd1);
    @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  task automatic sendQueued();
    while (txQ.size() > 0) applyStimulus(txQ.pop_front());
  endtask

  task automatic waitRelease(output int dt);
    int start;
    start = cycle;
    while (CPU_RESET === 1'b1 && cycle - start < 200) @(negedge CLK);
    dt = cycle - start;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cpu_reset"}, 32'(CPU_RESET), 32'd1);
    checkOutput({tag, "_busy"}, 32'(BUSY), 32'd1);
    checkOutput({tag, "_rx_ready"}, 32'(RX_READY), 32'd0);
    checkOutput({tag, "_load_we"}, 32'(LOAD_WE), 32'd0);
    checkOutput({tag, "_load_addr"}, 32'(LOAD_ADDRESS), 32'd0);
    checkOutput({tag, "_load_instr"}, 32'(LOAD_INSTRUCTION), 32'd0);
    checkOutput({tag, "_done"}, 32'(DONE), 32'd0);
    checkOutput({tag, "_error"}, 32'(ERROR), 32'd0);
    checkOutput({tag, "_err_code"}, 32'(ERR_CODE), 32'd0);
  endtask

  task automatic checkResetRelease(input string tag);
    int highs;
    highs = 0;
    RESET = 1'b0;
    for (int k = 0; k < RELEASE; k++) begin
      @(negedge CLK);
      if (CPU_RESET === 1'b1) highs++;
    end
    checkOutput({tag, "_hold_cycles"}, 32'(highs), 32'(RELEASE));
    @(negedge CLK);
    checkOutput({tag, "_cpu_released"}, 32'(CPU_RESET), 32'd0);
    checkOutput({tag, "_busy_after"}, 32'(BUSY), 32'd0);
    checkOutput({tag, "_done_after"}, 32'(DONE), 32'd0);
  endtask

  initial begin
    int dt;
    int start;
    logic [7:0] sum;
    logic [9:0] a;
    logic [7:0] b0, b1, b2;

    #1 RESET = 1'b1;
    repeat (3) @(negedge CLK);
    checkResetValues("por");
    checkResetRelease("por");

    // Noise before sync is swallowed
    applyStimulus(8'h00);
    checkOutput("discard_00_busy", 32'(BUSY), 32'd0);
    applyStimulus(8'hFF);
    checkOutput("discard_ff_busy", 32'(BUSY), 32'd0);

    $display("[TB] good frame");
    expQ.push_back({10'd0, 18'h01234});
    expQ.push_back({10'd1, 18'h3ABCD});
    applyStimulus(8'hA5);
    checkOutput("sync_cpu_reset", 32'(CPU_RESET), 32'd1);
    checkOutput("sync_busy", 32'(BUSY), 32'd1);
    txQ = '{8'h00, 8'h01, 8'h00, 8'h12, 8'h34, 8'h03, 8'hAB, 8'hCD, 8'h3E};
    sendQueued();
    checkOutput("done_before_release", 32'(DONE), 32'd0);
    waitRelease(dt);
    checkOutput("good_release_delay", 32'(dt), 32'd17);
    checkOutput("good_done", 32'(DONE), 32'd1);
    checkOutput("good_error", 32'(ERROR), 32'd0);
    checkOutput("good_err_code", 32'(ERR_CODE), 32'd0);
    checkOutput("addr_hold", 32'(LOAD_ADDRESS), 32'd1);
    checkOutput("instr_hold", 32'(LOAD_INSTRUCTION), 32'h3ABCD);

    $display("[TB] bad checksum frame");
    expQ.push_back({10'd0, 18'h01234});
    expQ.push_back({10'd1, 18'h3ABCD});
    applyStimulus(8'hA5);
    checkOutput("sync_clears_done", 32'(DONE), 32'd0);
    txQ = '{8'h00, 8'h01, 8'h00, 8'h12, 8'h34, 8'h03, 8'hAB, 8'hCD, 8'h3F};
    sendQueued();
    checkOutput("csum_error", 32'(ERROR), 32'd1);
    checkOutput("csum_err_code", 32'(ERR_CODE), 32'd1);
    checkOutput("csum_done", 32'(DONE), 32'd0);
    checkOutput("csum_busy", 32'(BUSY), 32'd0);
    repeat (30) @(negedge CLK);
    checkOutput("csum_cpu_held", 32'(CPU_RESET), 32'd1);

    expQ.push_back({10'd0, 18'h01234});
    expQ.push_back({10'd1, 18'h3ABCD});
    applyStimulus(8'hA5);
    checkOutput("sync_clears_error", 32'(ERROR), 32'd0);
    checkOutput("sync_clears_code", 32'(ERR_CODE), 32'd0);
    txQ = '{8'h00, 8'h01, 8'h00, 8'h12, 8'h34, 8'h03, 8'hAB, 8'hCD, 8'h3E};
    sendQueued();
    waitRelease(dt);
    checkOutput("recover_release_delay", 32'(dt), 32'd17);
    checkOutput("recover_done", 32'(DONE), 32'd1);

    $display("[TB] 1024-instruction frame");
    applyStimulus(8'hA5);
    sum = 8'h03 + 8'hFF;
    txQ = '{8'h03, 8'hFF};
    for (int i = 0; i < 1024; i++) begin
      a  = 10'(i);
      b0 = {6'h2B, a[9:8]};
      b1 = a[7:0];
      b2 = a[7:0] ^ 8'h5A;
      txQ.push_back(b0);
      txQ.push_back(b1);
      txQ.push_back(b2);
      sum = sum + b0 + b1 + b2;
      expQ.push_back({a, a[9:8], a[7:0], a[7:0] ^ 8'h5A});
    end
    txQ.push_back(8'h00 - sum);
    sendQueued();
    waitRelease(dt);
    checkOutput("big_release_delay", 32'(dt), 32'd17);
    checkOutput("big_done", 32'(DONE), 32'd1);
    checkOutput("big_last_addr", 32'(LOAD_ADDRESS), 32'd1023);
    checkOutput("big_writes_pending", 32'(expQ.size()), 32'd0);

    $display("[TB] timeout after CNT_LO");
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    start = cycle;
    while (ERROR !== 1'b1 && cycle - start < 300) @(negedge CLK);
    checkOutput("timeout_delay", 32'(cycle - start), 32'(TIMEOUT));
    checkOutput("timeout_err_code", 32'(ERR_CODE), 32'd2);
    checkOutput("timeout_busy", 32'(BUSY), 32'd0);
    checkOutput("timeout_cpu_reset", 32'(CPU_RESET), 32'd1);
    checkOutput("timeout_done", 32'(DONE), 32'd0);

    $display("[TB] reset during B1 of instruction 5");
    applyStimulus(8'hA5);
    txQ = '{8'h00, 8'h09};
    for (int i = 0; i < 5; i++) begin
      a = 10'(i);
      txQ.push_back(8'h01);
      txQ.push_back({a[3:0], 4'h7});
      txQ.push_back(8'hC0 + a[7:0]);
      expQ.push_back({a, 2'b01, a[3:0], 4'h7, 8'hC0 + a[7:0]});
    end
    sendQueued();
    applyStimulus(8'h02);
    checkOutput("pre_reset_addr", 32'(LOAD_ADDRESS), 32'd4);
    RX_DATA  = 8'h99;
    RX_VALID = 1'b1;
    #2 RESET = 1'b1;
    #1 checkResetValues("async");
    @(negedge CLK);
    RX_VALID = 1'b0;
    @(negedge CLK);
    checkResetRelease("mid");

    repeat (10) @(negedge CLK);
    checkOutput("pending_writes", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
